sc_inference_ctrl: RTL and testbench
====================================

SC_INFERENCE_CTRL -- requirements
Module: sc_inference_ctrl

Interface
REQ-001 The block SHALL have parameter N0, default 64, meaning network input vector width.
REQ-002 The block SHALL have parameter N2, default 10, meaning number of output neurons (classes), N2 >= 2.
REQ-003 The block SHALL have parameter L, default 256, meaning accumulation window in clock cycles (bitstream length), L >= 1.
REQ-004 The block SHALL have parameter W, default 4, meaning warm-up cycles discarded after the network leaves reset, W >= 0.
REQ-005 The block SHALL have derived constants CW = clog2(L+1) (count width) and IW = clog2(N2) (class index width).
REQ-006 The block SHALL have port clk, input, 1, meaning the single clock; all logic SHALL be rising-edge.
REQ-007 The block SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-008 The block SHALL have port in_valid, input, 1, meaning din_in is valid.
REQ-009 The block SHALL have port in_ready, output, 1, meaning the block can accept an input.
REQ-010 The block SHALL have port din_in, input, N0, meaning the input vector to classify.
REQ-011 The block SHALL have port abort, input, 1, meaning cancel the current inference.
REQ-012 The block SHALL have port net_reset, output, 1, meaning reset to the network datapath.
REQ-013 The block SHALL have port net_din, output, N0, meaning the held input vector to the network.
REQ-014 The block SHALL have port net_dout, input, N2, meaning per-cycle output bits from the network.
REQ-015 The block SHALL have port result_valid, output, 1, meaning the result is valid.
REQ-016 The block SHALL have port result_ready, input, 1, meaning the consumer accepts the result.
REQ-017 The block SHALL have port counts, output, N2*CW, meaning per-class ones count, class i at bits [i*CW +: CW].
REQ-018 The block SHALL have port class_idx, output, IW, meaning argmax class.

Function
REQ-019 The FSM SHALL have states IDLE, FLUSH, WARMUP, ACCUM, SELECT and DONE.
REQ-020 in_ready SHALL be 1 only in IDLE.
REQ-021 On in_valid && in_ready, din_in SHALL be latched into net_din, counters SHALL be cleared, and the state SHALL become FLUSH.
REQ-022 net_din SHALL hold its value until the next accepted input.
REQ-023 net_reset SHALL be 1 in IDLE and FLUSH and while reset is high; otherwise it SHALL be 0.
REQ-024 FLUSH SHALL last exactly 1 cycle, then go to WARMUP, or to ACCUM if W = 0.
REQ-025 WARMUP SHALL last exactly W cycles; net_dout SHALL be ignored during WARMUP.
REQ-026 ACCUM SHALL last exactly L cycles; each cycle, count[i] SHALL increment by 1 when net_dout[i] = 1.
REQ-027 count[i] SHALL never exceed L, so no saturation or wrap logic is needed.
REQ-028 SELECT SHALL last exactly N2 cycles and scan index 0..N2-1, one index per cycle, tracking the running maximum and its index.
REQ-029 In SELECT, replacement SHALL occur only on strictly greater counts; on ties, the lowest index wins.
REQ-030 After SELECT the state SHALL be DONE; result_valid SHALL be 1 only in DONE.
REQ-031 In DONE, counts and class_idx SHALL be stable.
REQ-032 On result_valid && result_ready, the state SHALL return to IDLE on the next edge; in_ready SHALL rise that cycle.
REQ-033 Latency SHALL be: result_valid rises exactly 1+W+L+N2 cycles after the input-accept edge.
REQ-034 abort high in FLUSH, WARMUP, ACCUM or SELECT SHALL force IDLE on the next edge with counts cleared and result_valid 0.
REQ-035 abort SHALL be ignored in IDLE and DONE.
REQ-036 abort and in_valid in the same IDLE cycle SHALL result in the input being accepted.
REQ-037 counts and class_idx SHALL hold their last values outside DONE; their value is only meaningful in DONE.

Reset
REQ-038 While reset is high: state SHALL be IDLE; in_ready = 1; net_reset = 1; result_valid = 0; counts = 0; class_idx = 0; net_din = 0.
REQ-039 Reset SHALL take priority over all other inputs, including mid-run, with no residual state after release.

Verification (N0=8, N2=4, L=16, W=2)
REQ-040 Accept a vector, net_dout = 4'b0101 constant -> result_valid exactly 23 cycles after the accept edge; counts = {0,16,0,16} (class3..0); class_idx = 0 (tie, lowest index).
REQ-041 net_dout[2] = 1 always and net_dout[1] toggling -> counts[2] = 16, counts[1] = 8, class_idx = 2.
REQ-042 net_dout = 4'b1000 only during FLUSH/WARMUP, 0 in ACCUM -> all counts 0, class_idx = 0.
REQ-043 Hold result_ready = 0 for 5 cycles in DONE -> result_valid, counts and class_idx stable and in_ready = 0; on result_ready = 1 -> IDLE next cycle, in_ready = 1, net_reset = 1.
REQ-044 Assert abort at ACCUM cycle 7 -> IDLE next edge, counts = 0, in_ready = 1, no result_valid pulse; a new input then completes normally.
REQ-045 Assert reset at SELECT cycle 2 -> all outputs at reset values on the next edge; back-to-back accept after release yields correct counts.

Source files
------------

// File: rtl/sc_inference_ctrl.sv
// Stochastic-computing inference controller: holds an input vector on the network and counts ones
// per class over a fixed window. It then selects the argmax and hands the result over with ready/valid.
module sc_inference_ctrl #(
  parameter int unsigned N0 = 64,
  parameter int unsigned N2 = 10,
  parameter int unsigned L  = 256,
  parameter int unsigned W  = 4,
  localparam int unsigned CW = $clog2(L + 1),
  localparam int unsigned IW = $clog2(N2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N0-1:0]    din_in,
  input  logic             abort,
  output logic             net_reset,
  output logic [N0-1:0]    net_din,
  input  logic [N2-1:0]    net_dout,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [N2*CW-1:0] counts,
  output logic [IW-1:0]    class_idx
);

  // One phase counter is shared by WARMUP, ACCUM and SELECT, so it must cover the longest phase.
  localparam int unsigned MaxCyc = (L > N2) ? ((L > W) ? L : W) : ((N2 > W) ? N2 : W);
  localparam int unsigned CycW   = $clog2(MaxCyc + 1);
  localparam logic [CycW-1:0] WLast = CycW'((W > 0) ? W - 1 : 0);
  localparam logic [CycW-1:0] LLast = CycW'(L - 1);
  localparam logic [CycW-1:0] SLast = CycW'(N2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFlush,
    StWarmup,
    StAccum,
    StSelect,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CycW-1:0] cyc_q, cyc_d;
  logic [N0-1:0]   net_din_q;
  logic [CW-1:0]   count_q [N2];
  logic [CW-1:0]   max_q;
  logic [IW-1:0]   best_q;

  logic          accept;
  logic          cnt_clr;
  logic          acc_en;
  logic          sel_en;
  logic [IW-1:0] sel_idx;
  logic [CW-1:0] sel_cnt;

  assign sel_idx = cyc_q[IW-1:0];
  assign sel_cnt = count_q[sel_idx];

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q + CycW'(1);
    accept  = 1'b0;
    cnt_clr = 1'b0;
    acc_en  = 1'b0;
    sel_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cyc_d = '0;
        if (in_valid) begin
          accept  = 1'b1;
          cnt_clr = 1'b1;
          state_d = StFlush;
        end
      end
      StFlush: begin
        cyc_d   = '0;
        state_d = (W == 0) ? StAccum : StWarmup;
      end
      StWarmup: begin
        if (cyc_q == WLast) begin
          cyc_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        acc_en = 1'b1;
        if (cyc_q == LLast) begin
          cyc_d   = '0;
          state_d = StSelect;
        end
      end
      StSelect: begin
        sel_en = 1'b1;
        if (cyc_q == SLast) begin
          cyc_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        cyc_d = '0;
        if (result_ready) state_d = StIdle;
      end
      default: begin
        cyc_d   = '0;
        state_d = StIdle;
      end
    endcase

    // Abort only cancels an in-flight inference; IDLE and DONE ignore it.
    if (abort && (state_q inside {StFlush, StWarmup, StAccum, StSelect})) begin
      state_d = StIdle;
      cyc_d   = '0;
      cnt_clr = 1'b1;
      acc_en  = 1'b0;
      sel_en  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cyc_q     <= '0;
      net_din_q <= '0;
      max_q     <= '0;
      best_q    <= '0;
      for (int i = 0; i < N2; i++) count_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      if (accept) net_din_q <= din_in;
      for (int i = 0; i < N2; i++) begin
        if (cnt_clr) begin
          count_q[i] <= '0;
        end else if (acc_en && net_dout[i]) begin
          count_q[i] <= count_q[i] + CW'(1);
        end
      end
      // First SELECT cycle loads index 0; later ones replace only on a strictly larger count.
      if (sel_en && ((cyc_q == '0) || (sel_cnt > max_q))) begin
        max_q  <= sel_cnt;
        best_q <= sel_idx;
      end
    end
  end

  for (genvar g = 0; g < N2; g++) begin : g_counts
    assign counts[g*CW +: CW] = count_q[g];
  end

  assign in_ready     = (state_q == StIdle);
  assign net_reset    = reset || (state_q == StIdle) || (state_q == StFlush);
  assign result_valid = (state_q == StDone);
  assign net_din      = net_din_q;
  assign class_idx    = best_q;

endmodule

// File: tb/tb_sc_inference_ctrl.sv
// Bench for sc_inference_ctrl: directed table, abort/reset corner sequences and random
// runs scored against a window-sum/argmax model.
module tb_sc_inference_ctrl;

  localparam int unsigned N0  = 8;
  localparam int unsigned N2  = 4;
  localparam int unsigned L   = 16;
  localparam int unsigned W   = 2;
  localparam int unsigned CW  = 5;
  localparam int unsigned IW  = 2;
  localparam int unsigned Lat = 1 + W + L + N2;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [N0-1:0]    din_in;
  logic             abort;
  logic             net_reset;
  logic [N0-1:0]    net_din;
  logic [N2-1:0]    net_dout;
  logic             result_valid;
  logic             result_ready;
  logic [N2*CW-1:0] counts;
  logic [IW-1:0]    class_idx;

  sc_inference_ctrl #(
    .N0 (N0),
    .N2 (N2),
    .L  (L),
    .W  (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .din_in       (din_in),
    .abort        (abort),
    .net_reset    (net_reset),
    .net_din      (net_din),
    .net_dout     (net_dout),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .counts       (counts),
    .class_idx    (class_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  logic [N2-1:0] stim [Lat];
  int            exp_cnt [N2];
  int            exp_idx;

  typedef struct {
    logic [N0-1:0] din;
    int            kind;
    logic          with_abort;
    int            hold;
    int            c0, c1, c2, c3;
    int            idx;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d", name, act, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dut_count(input int i);
    return 32'(counts[i*CW +: CW]);
  endfunction

  // Stimulus index k is the k-th cycle after the accept edge (k = 0 is FLUSH).
  task automatic gen_stim(input int kind);
    for (int k = 0; k < Lat; k++) begin
      case (kind)
        0:       stim[k] = 4'b0101;
        1:       stim[k] = (k % 2 == 1) ? 4'b0110 : 4'b0100;
        2:       stim[k] = (k <= W) ? 4'b1000 : 4'b0000;
        default: stim[k] = N2'($urandom);
      endcase
    end
  endtask

  // Reference: sum each class bit over the L-cycle window after flush+warm-up, then argmax
  // with the lowest index winning ties.
  task automatic model();
    for (int i = 0; i < N2; i++) begin
      exp_cnt[i] = 0;
      for (int k = W + 1; k <= W + L; k++) exp_cnt[i] += int'(stim[k][i]);
    end
    exp_idx = 0;
    for (int i = 1; i < N2; i++) if (exp_cnt[i] > exp_cnt[exp_idx]) exp_idx = i;
  endtask

  task automatic accept_vec(input logic [N0-1:0] v, input logic with_abort);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    din_in   = v;
    abort    = with_abort;
    tick();
    in_valid = 1'b0;
    abort    = 1'b0;
    din_in   = N0'($urandom);
    check("net_din_latched", 32'(net_din), 32'(v));
  endtask

  // Steps through one inference. stop_kind 1 raises abort, 2 raises reset, in cycle stop_k;
  // on a stop the task returns right after that edge with the control still asserted.
  task automatic run_body(input int stop_k, input int stop_kind);
    for (int k = 0; k < Lat; k++) begin
      check($sformatf("result_valid_low_k%0d", k), 32'(result_valid), 32'd0);
      check($sformatf("in_ready_low_k%0d", k), 32'(in_ready), 32'd0);
      check($sformatf("net_reset_k%0d", k), 32'(net_reset), (k == 0) ? 32'd1 : 32'd0);
      if (k == stop_k) begin
        if (stop_kind == 1) abort = 1'b1;
        else reset = 1'b1;
      end
      net_dout = stim[k];
      tick();
      if (k == stop_k) return;
    end
    check("result_valid_at_latency", 32'(result_valid), 32'd1);
  endtask

  task automatic compare_result(input string tag);
    for (int i = 0; i < N2; i++)
      check($sformatf("%s_count%0d", tag, i), dut_count(i), 32'(exp_cnt[i]));
    check($sformatf("%s_class_idx", tag), 32'(class_idx), 32'(exp_idx));
  endtask

  task automatic release_result(input int hold);
    for (int h = 0; h < hold; h++) begin
      result_ready = 1'b0;
      net_dout     = N2'($urandom);
      abort        = 1'($urandom);
      check("done_hold_valid", 32'(result_valid), 32'd1);
      check("done_hold_in_ready", 32'(in_ready), 32'd0);
      compare_result("done_hold");
      tick();
    end
    abort        = 1'b0;
    result_ready = 1'b1;
    check("done_valid_at_ready", 32'(result_valid), 32'd1);
    tick();
    result_ready = 1'b0;
    check("post_done_in_ready", 32'(in_ready), 32'd1);
    check("post_done_valid", 32'(result_valid), 32'd0);
    check("post_done_net_reset", 32'(net_reset), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check($sformatf("%s_in_ready", tag), 32'(in_ready), 32'd1);
    check($sformatf("%s_net_reset", tag), 32'(net_reset), 32'd1);
    check($sformatf("%s_result_valid", tag), 32'(result_valid), 32'd0);
    check($sformatf("%s_counts", tag), 32'(counts), 32'd0);
    check($sformatf("%s_class_idx", tag), 32'(class_idx), 32'd0);
    check($sformatf("%s_net_din", tag), 32'(net_din), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    reset        = 1'b1;
    in_valid     = 1'b0;
    din_in       = '0;
    abort        = 1'b0;
    net_dout     = '0;
    result_ready = 1'b0;

    tbl[0] = '{din: 8'hA5, kind: 0, with_abort: 1'b0, hold: 0,
               c0: 16, c1: 0, c2: 16, c3: 0, idx: 0};
    tbl[1] = '{din: 8'h3C, kind: 1, with_abort: 1'b0, hold: 5,
               c0: 0, c1: 8, c2: 16, c3: 0, idx: 2};
    tbl[2] = '{din: 8'hFF, kind: 2, with_abort: 1'b0, hold: 1,
               c0: 0, c1: 0, c2: 0, c3: 0, idx: 0};
    tbl[3] = '{din: 8'h81, kind: 1, with_abort: 1'b1, hold: 0,
               c0: 0, c1: 8, c2: 16, c3: 0, idx: 2};

    tick();
    tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();
    check("idle_net_reset", 32'(net_reset), 32'd1);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    for (int t = 0; t < 4; t++) begin
      gen_stim(tbl[t].kind);
      exp_cnt[0] = tbl[t].c0;
      exp_cnt[1] = tbl[t].c1;
      exp_cnt[2] = tbl[t].c2;
      exp_cnt[3] = tbl[t].c3;
      exp_idx    = tbl[t].idx;
      accept_vec(tbl[t].din, tbl[t].with_abort);
      run_body(-1, 0);
      compare_result($sformatf("tbl%0d", t));
      release_result(tbl[t].hold);
    end

    // Abort in ACCUM cycle 7, then a clean run.
    gen_stim(3);
    accept_vec(8'h5A, 1'b0);
    run_body(W + 1 + 7, 1);
    abort = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_valid", 32'(result_valid), 32'd0);
    check("abort_counts", 32'(counts), 32'd0);
    check("abort_net_reset", 32'(net_reset), 32'd1);
    for (int h = 0; h < 4; h++) begin
      tick();
      check("abort_idle_valid", 32'(result_valid), 32'd0);
      check("abort_idle_in_ready", 32'(in_ready), 32'd1);
    end
    gen_stim(3);
    model();
    accept_vec(8'hC3, 1'b0);
    run_body(-1, 0);
    compare_result("after_abort");
    release_result(0);

    // Reset in SELECT cycle 2, then back-to-back accept on release.
    gen_stim(3);
    accept_vec(8'h77, 1'b0);
    run_body(1 + W + L + 2, 2);
    check_reset_values("midrun_reset");
    reset = 1'b0;
    gen_stim(3);
    model();
    accept_vec(8'h12, 1'b0);
    run_body(-1, 0);
    compare_result("after_reset");
    release_result(0);

    for (int r = 0; r < 8; r++) begin
      gen_stim(3);
      model();
      accept_vec(N0'($urandom), 1'($urandom));
      run_body(-1, 0);
      compare_result($sformatf("rand%0d", r));
      release_result(int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
